// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver: recovers bytes from rx with a local
// bit-timing counter, sampling mid-bit, and flags bad stop bits.
module uart_rx #(
    parameter int SOURCE_CLK = 12000000,
    parameter int BAUD       = 9600,
    parameter int CNTR_W     = 16
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int N    = SOURCE_CLK / BAUD;
    localparam int HALF = N / 2;

    localparam logic [CNTR_W-1:0] BIT_LAST  = CNTR_W'(N - 1);
    localparam logic [CNTR_W-1:0] HALF_LAST = CNTR_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    logic [CNTR_W-1:0]   cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift_reg;
    logic                rx_m;
    logic                rx_s;
    logic                rx_p;
    logic                rx_fall;

    // A held-low line never re-arms the receiver; only a real 1->0 transition does.
    assign rx_fall   = rx_p & ~rx_s;
    assign dbg_state = state;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_p      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            rx_p      <= rx_s;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            // Line bounced back high before mid-start: glitch, drop it.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx at default timing and at N=16.
module tb_uart_rx;

    logic       hwclk;
    logic       rst_n;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       valid_a;
    logic       valid_b;
    logic       ferr_a;
    logic       ferr_b;
    logic       busy_a;
    logic       busy_b;
    logic [1:0] st_a;
    logic [1:0] st_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_a[$];
    logic [7:0] got_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] got_b[$];

    int valid_cyc_a  = -1;
    int ferr_cyc_a   = -1;
    int n_ferr_a     = 0;
    int n_ferr_b     = 0;
    int busy_rise_a  = -1;
    int busy_fall_a  = -1;
    int n_busy_rise_a = 0;
    logic busy_a_prev = 1'b0;

    uart_rx dut_a (
        .hwclk(hwclk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a),
        .rx_valid(valid_a), .frame_err(ferr_a), .busy(busy_a), .dbg_state(st_a)
    );

    uart_rx #(.SOURCE_CLK(16), .BAUD(1), .CNTR_W(5)) dut_b (
        .hwclk(hwclk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b),
        .rx_valid(valid_b), .frame_err(ferr_b), .busy(busy_b), .dbg_state(st_b)
    );

    // clock / reset
    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;
    always @(posedge hwclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // monitors: collect strobes and busy edges, check strobe exclusivity
    always @(negedge hwclk) begin
        if (valid_a) begin
            got_a.push_back(data_a);
            valid_cyc_a = cyc;
        end
        if (ferr_a) begin
            n_ferr_a++;
            ferr_cyc_a = cyc;
        end
        if (valid_a || ferr_a) chk("a_excl", {31'b0, valid_a & ferr_a}, 32'd0);
        if (busy_a && !busy_a_prev) begin
            busy_rise_a = cyc;
            n_busy_rise_a++;
        end
        if (!busy_a && busy_a_prev) busy_fall_a = cyc;
        busy_a_prev = busy_a;
        if (valid_b) got_b.push_back(data_b);
        if (ferr_b) n_ferr_b++;
        if (valid_b || ferr_b) chk("b_excl", {31'b0, valid_b & ferr_b}, 32'd0);
    end

    // driver tasks (call right after a falling clock edge)
    task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_bit,
                              input real period, output int t_start);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            if (sel == 0) rx_a = f[i];
            else          rx_b = f[i];
            while (cyc < t_start + $rtoi((i + 1) * period + 0.5)) @(negedge hwclk);
        end
    endtask

    task automatic idle(input int sel, input int ncyc);
        if (sel == 0) rx_a = 1'b1;
        else          rx_b = 1'b1;
        repeat (ncyc) @(negedge hwclk);
    endtask

    // scoreboard: compare received bytes against the expected queue
    task automatic score(input int sel, input string tag);
        int ne;
        int ng;
        logic [7:0] e;
        logic [7:0] g;
        ne = (sel == 0) ? exp_a.size() : exp_b.size();
        ng = (sel == 0) ? got_a.size() : got_b.size();
        chk({tag, "_count"}, 32'(ng), 32'(ne));
        for (int i = 0; i < ne && i < ng; i++) begin
            if (sel == 0) begin e = exp_a.pop_front(); g = got_a.pop_front(); end
            else          begin e = exp_b.pop_front(); g = got_b.pop_front(); end
            chk({tag, "_data"}, 32'(g), 32'(e));
        end
        if (sel == 0) begin exp_a.delete(); got_a.delete(); end
        else          begin exp_b.delete(); got_b.delete(); end
    endtask

    localparam real BIT_A = 1250.0;
    localparam int  LAT_A = 11875 + 3;

    initial begin
        int t0;
        int rises;
        int nf;
        int exp_err_b;
        logic [7:0] b;
        logic bad;
        real period;

        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        exp_err_b = 0;
        repeat (3) @(negedge hwclk);
        chk("rst_data", 32'(data_a), 32'h00);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_ferr", 32'(ferr_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_state", 32'(st_a), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge hwclk);
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        chk("post_rst_valid_b", 32'(valid_b), 32'd0);

        // single byte at exact baud
        exp_a.push_back(8'hA5);
        send_frame(0, 8'hA5, 1'b1, BIT_A, t0);
        idle(0, 200);
        score(0, "single");
        chk("single_lat", 32'(valid_cyc_a), 32'(t0 + LAT_A));
        chk("single_ferr", 32'(n_ferr_a), 32'd0);
        chk("single_hold", 32'(data_a), 32'hA5);

        // start glitch: busy for HALF cycles, no output
        t0 = cyc;
        rx_a = 1'b0;
        repeat (100) @(negedge hwclk);
        idle(0, 800);
        chk("glitch_rise", 32'(busy_rise_a), 32'(t0 + 3));
        chk("glitch_width", 32'(busy_fall_a - busy_rise_a), 32'd625);
        score(0, "glitch");
        chk("glitch_ferr", 32'(n_ferr_a), 32'd0);
        chk("glitch_data", 32'(data_a), 32'hA5);

        // framing error followed by a break
        rises = n_busy_rise_a;
        send_frame(0, 8'h3C, 1'b0, BIT_A, t0);
        repeat (3750) @(negedge hwclk);
        chk("brk_norestart", 32'(n_busy_rise_a), 32'(rises + 1));
        chk("brk_busy", 32'(busy_a), 32'd0);
        idle(0, 500);
        chk("brk_high_norestart", 32'(n_busy_rise_a), 32'(rises + 1));
        chk("ferr_count", 32'(n_ferr_a), 32'd1);
        chk("ferr_lat", 32'(ferr_cyc_a), 32'(t0 + LAT_A));
        score(0, "ferr");
        chk("ferr_data_kept", 32'(data_a), 32'hA5);

        // reset during data bit 4, held until that frame has left the line
        fork
            begin
                int ts;
                send_frame(0, 8'h55, 1'b1, BIT_A, ts);
            end
            begin
                repeat (5 * 1250 + 600) @(negedge hwclk);
                chk("pre_rst_busy", 32'(busy_a), 32'd1);
                #2 rst_n = 1'b0;
                #1;
                chk("arst_data", 32'(data_a), 32'h00);
                chk("arst_busy", 32'(busy_a), 32'd0);
                chk("arst_valid", 32'(valid_a), 32'd0);
                chk("arst_ferr", 32'(ferr_a), 32'd0);
            end
        join
        @(negedge hwclk);
        rst_n = 1'b1;
        idle(0, 100);
        score(0, "aborted");
        exp_a.push_back(8'hC3);
        send_frame(0, 8'hC3, 1'b1, BIT_A, t0);
        idle(0, 200);
        score(0, "after_rst");
        chk("after_rst_lat", 32'(valid_cyc_a), 32'(t0 + LAT_A));
        chk("after_rst_ferr", 32'(n_ferr_a), 32'd1);

        // back-to-back at N=16, transmitter 2% fast
        n_ferr_b = 0;
        got_b.delete();
        period = 16.0 / 1.02;
        exp_b.push_back(8'h00);
        exp_b.push_back(8'hFF);
        exp_b.push_back(8'h81);
        send_frame(1, 8'h00, 1'b1, period, t0);
        send_frame(1, 8'hFF, 1'b1, period, t0);
        send_frame(1, 8'h81, 1'b1, period, t0);
        idle(1, 40);
        score(1, "b2b");
        chk("b2b_ferr", 32'(n_ferr_b), 32'd0);

        // random bytes, baud error within +-1.9%, occasional bad stop bit
        n_ferr_b = 0;
        for (int k = 0; k < 30; k++) begin
            b      = 8'($urandom_range(0, 255));
            bad    = ($urandom_range(0, 5) == 0);
            period = 16.0 + (real'($urandom_range(0, 60)) - 30.0) / 100.0;
            send_frame(1, b, !bad, period, t0);
            if (bad) begin
                exp_err_b++;
                idle(1, 20);
            end else begin
                exp_b.push_back(b);
                idle(1, 16 * $urandom_range(0, 2));
            end
        end
        idle(1, 40);
        score(1, "rand");
        nf = n_ferr_b;
        chk("rand_ferr", 32'(nf), 32'(exp_err_b));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
